stack_arbiter: RTL and testbench

//  Shares one 8-entry LIFO stack between two requesters using round-robin arbitration.

---
 rtl/stack_arbiter.sv | 148 ++++++++++++++
 tb/tb_stack_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// Round-robin arbiter that shares one external LIFO stack between two requesters.
// Each transaction runs IDLE -> ISSUE -> CAPT -> RESP; an error goes IDLE -> RESP without touching the stack.
module stack_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int LVL_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              cmd0,
    input  logic              cmd1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              stk_enable,
    output logic              stk_push_pop,
    output logic [DATA_W-1:0] stk_data_in,
    input  logic [DATA_W-1:0] stk_data_out,
    input  logic              stk_empty,
    input  logic              stk_full,
    output logic [LVL_W-1:0]  level,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

    state_t              state_reg, state_next;
    logic                grant_reg, grant_next;
    logic                last_grant_reg, last_grant_next;
    logic                cmd_reg, cmd_next;
    logic                err_reg, err_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [LVL_W-1:0]    level_reg, level_next;
    logic                sel;
    logic [1:0]          req_vec, cmd_vec;
    logic [DATA_W-1:0]   wdata_vec [2];

    assign req_vec      = {req1, req0};
    assign cmd_vec      = {cmd1, cmd0};
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;
    assign level        = level_reg;

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        cmd_next        = cmd_reg;
        err_next        = err_reg;
        wdata_next      = wdata_reg;
        level_next      = level_reg;
        sel             = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    // On a tie the requester that did not win last time goes first.
                    sel             = (req_vec == 2'b11) ? ~last_grant_reg : req_vec[1];
                    grant_next      = sel;
                    last_grant_next = sel;
                    cmd_next        = cmd_vec[sel];
                    wdata_next      = wdata_vec[sel];
                    err_next        = cmd_vec[sel] ? stk_full : stk_empty;
                    state_next      = err_next ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_reg)
                    level_next = (level_reg == LVL_MAX) ? level_reg : level_reg + 1'b1;
                else
                    level_next = (level_reg == '0) ? level_reg : level_reg - 1'b1;
                state_next = CAPT;
            end
            CAPT:    state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            cmd_reg        <= 1'b0;
            err_reg        <= 1'b0;
            wdata_reg      <= '0;
            level_reg      <= '0;
            stk_enable     <= 1'b0;
            stk_push_pop   <= 1'b0;
            stk_data_in    <= '0;
            busy           <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            cmd_reg        <= cmd_next;
            err_reg        <= err_next;
            wdata_reg      <= wdata_next;
            level_reg      <= level_next;
            stk_enable     <= (state_next == ISSUE);
            busy           <= (state_next != IDLE);
            if (state_reg == IDLE && state_next == ISSUE) begin
                stk_push_pop <= cmd_next;
                stk_data_in  <= wdata_next;
            end
        end
    end

    // Per-requester response registers: ack/err live only for the RESP cycle, rdata holds.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        localparam logic ME = (gi == 1);
        logic              ack_reg;
        logic              err_out_reg;
        logic [DATA_W-1:0] rdata_reg;
        logic              respond;

        assign respond = (state_next == RESP) && (grant_next == ME);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ack_reg     <= 1'b0;
                err_out_reg <= 1'b0;
                rdata_reg   <= '0;
            end else begin
                ack_reg     <= respond;
                err_out_reg <= respond && err_next;
                if (state_reg == IDLE && state_next != IDLE && grant_next == ME)
                    rdata_reg <= '0;
                else if (state_reg == CAPT && grant_reg == ME && !cmd_reg)
                    rdata_reg <= stk_data_out;
            end
        end
    end

    assign ack0   = g_req[0].ack_reg;
    assign ack1   = g_req[1].ack_reg;
    assign err0   = g_req[0].err_out_reg;
    assign err1   = g_req[1].err_out_reg;
    assign rdata0 = g_req[0].rdata_reg;
    assign rdata1 = g_req[1].rdata_reg;
endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: an 8-deep stack model on the stk_* side, table vectors,
// hand sequences for reset/fairness/protocol corners, and a queue-based random model.
module tb_stack_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, cmd0, cmd1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       stk_enable, stk_push_pop;
    logic [7:0] stk_data_in, stk_data_out;
    logic       stk_empty, stk_full;
    logic [3:0] level;
    logic       busy;

    always #5 clk = ~clk;

    stack_arbiter #(.DATA_W(8), .DEPTH(8), .LVL_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .stk_enable(stk_enable), .stk_push_pop(stk_push_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_empty(stk_empty), .stk_full(stk_full),
        .level(level), .busy(busy)
    );

    // External stack: a pop result appears on stk_data_out the cycle after the enable.
    logic [7:0] smem [8];
    int         sp;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp           <= 0;
            stk_data_out <= 8'h00;
        end else if (stk_enable) begin
            if (stk_push_pop) begin
                if (sp < 8) begin
                    smem[sp] <= stk_data_in;
                    sp       <= sp + 1;
                end
            end else if (sp > 0) begin
                stk_data_out <= smem[sp-1];
                sp           <= sp - 1;
            end
        end
    end
    assign stk_empty = (sp == 0);
    assign stk_full  = (sp == 8);

    int         en_count = 0, ack_total = 0, cons_bad = 0;
    logic       last_pp = 1'b0;
    logic [7:0] last_din = 8'h00;
    always @(negedge clk) begin
        if (!reset) begin
            if (stk_enable) begin
                en_count <= en_count + 1;
                last_pp  <= stk_push_pop;
                last_din <= stk_data_in;
            end
            ack_total <= ack_total + int'(ack0) + int'(ack1);
            if (((level == 4'd0) != stk_empty) || ((level == 4'd8) != stk_full))
                cons_bad <= cons_bad + 1;
        end
    end

    int checks = 0, errors = 0, stray = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Starts at a negedge with the DUT idle; lat counts negedges until ack (3 normal, 1 error).
    task automatic do_txn(input int who, input logic cmd, input logic [7:0] data,
                          output logic got_err, output logic [7:0] got_rd,
                          output int lat, output logic got_ack);
        int n;
        got_ack = 1'b0; got_err = 1'b0; got_rd = 8'h00; lat = -1; n = 0;
        if (who == 0) begin req0 = 1'b1; cmd0 = cmd; wdata0 = data; end
        else          begin req1 = 1'b1; cmd1 = cmd; wdata1 = data; end
        while (!got_ack && n < 20) begin
            @(negedge clk);
            n++;
            if ((who == 0) ? ack1 : ack0) stray++;
            if ((who == 0) ? ack0 : ack1) begin
                got_ack = 1'b1;
                lat     = n;
                got_err = (who == 0) ? err0 : err1;
                got_rd  = (who == 0) ? rdata0 : rdata1;
            end
        end
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        int         who;
        logic       cmd;
        logic [7:0] data;
        logic       exp_err;
        logic [7:0] exp_rd;
        int         exp_lat;
        int         exp_level;
    } vec_t;

    vec_t       vecs [18];
    logic       g_err, g_ack, r_cmd;
    logic [7:0] g_rd, r_data, exp_rd;
    int         lat, e0, a0, n, who;
    int         gseq [$];
    logic [7:0] model [$];
    logic       exp_err;

    initial begin
        // Lifecycle of requester 0: fill to 8, overflow once, drain, underflow once.
        for (int i = 0; i < 8; i++) vecs[i] = '{0, 1'b1, 8'(i + 1), 1'b0, 8'h00, 3, i + 1};
        vecs[8] = '{0, 1'b1, 8'd9, 1'b1, 8'h00, 1, 8};
        for (int i = 0; i < 8; i++) vecs[9 + i] = '{0, 1'b0, 8'h00, 1'b0, 8'(8 - i), 3, 7 - i};
        vecs[17] = '{0, 1'b0, 8'h00, 1'b1, 8'h00, 1, 0};

        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; cmd0 = 1'b0; cmd1 = 1'b0;
        wdata0 = 8'h00; wdata1 = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ack0", int'(ack0), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_level", int'(level), 0);
        check("rst_stk_enable", int'(stk_enable), 0);

        // 1: request held through reset, push 0xA5 after release
        req0 = 1'b1; cmd0 = 1'b1; wdata0 = 8'hA5;
        @(negedge clk);
        check("t1_busy_in_reset", int'(busy), 0);
        reset = 1'b0;
        e0 = en_count;
        do_txn(0, 1'b1, 8'hA5, g_err, g_rd, lat, g_ack);
        check("t1_ack", int'(g_ack), 1);
        check("t1_lat", lat, 3);
        check("t1_err", int'(g_err), 0);
        check("t1_en_pulses", en_count - e0, 1);
        check("t1_push_pop", int'(last_pp), 1);
        check("t1_data_in", int'(last_din), 8'hA5);
        check("t1_level", int'(level), 1);

        // 2: pop on an empty stack errors immediately and never strobes the stack
        do_reset();
        e0 = en_count;
        do_txn(1, 1'b0, 8'h00, g_err, g_rd, lat, g_ack);
        check("t2_lat", lat, 1);
        check("t2_err", int'(g_err), 1);
        check("t2_rdata", int'(g_rd), 0);
        check("t2_en_pulses", en_count - e0, 0);
        check("t2_level", int'(level), 0);

        // 3: both requesters hold req high; grants must alternate starting with 0
        do_reset();
        req0 = 1'b1; cmd0 = 1'b1; wdata0 = 8'h11;
        req1 = 1'b1; cmd1 = 1'b1; wdata1 = 8'h22;
        n = 0;
        while (gseq.size() < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (ack0) gseq.push_back(0);
            if (ack1) gseq.push_back(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t3_grant_count", gseq.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t3_grant%0d", k), (k < gseq.size()) ? gseq[k] : -1, k % 2);
        check("t3_level", int'(level), 4);

        // 4: table of fill/overflow/drain/underflow
        do_reset();
        for (int i = 0; i < 18; i++) begin
            e0 = en_count;
            do_txn(vecs[i].who, vecs[i].cmd, vecs[i].data, g_err, g_rd, lat, g_ack);
            check($sformatf("t4_v%0d_err", i), int'(g_err), int'(vecs[i].exp_err));
            check($sformatf("t4_v%0d_rdata", i), int'(g_rd), int'(vecs[i].exp_rd));
            check($sformatf("t4_v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("t4_v%0d_level", i), int'(level), vecs[i].exp_level);
            check($sformatf("t4_v%0d_en", i), en_count - e0, vecs[i].exp_err ? 0 : 1);
        end

        // 6: req dropped right after being sampled; the transaction still completes
        req0 = 1'b1; cmd0 = 1'b1; wdata0 = 8'h5A;
        @(negedge clk);
        req0 = 1'b0;
        check("t6_busy", int'(busy), 1);
        n = 1; lat = -1;
        while (lat < 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (ack0) lat = n;
        end
        @(negedge clk);
        check("t6_lat", lat, 3);
        check("t6_level", int'(level), 1);

        // 5: reset during ISSUE, then during CAPT: no ack, back to idle and empty
        a0 = ack_total;
        req0 = 1'b1; cmd0 = 1'b1; wdata0 = 8'h33;
        @(negedge clk);
        check("t5_issue_enable", int'(stk_enable), 1);
        reset = 1'b1; req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5a_busy", int'(busy), 0);
        check("t5a_level", int'(level), 0);
        req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5b_busy", int'(busy), 0);
        check("t5b_level", int'(level), 0);
        check("t5_no_ack", ack_total - a0, 0);
        do_txn(0, 1'b1, 8'h44, g_err, g_rd, lat, g_ack);
        check("t5_after_lat", lat, 3);
        check("t5_after_err", int'(g_err), 0);
        check("t5_after_level", int'(level), 1);

        // Random traffic against a LIFO queue model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            who    = int'($urandom_range(0, 1));
            r_cmd  = (i < 30) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r_data = 8'($urandom);
            exp_rd = 8'h00;
            if (r_cmd) begin
                exp_err = (model.size() == 8);
                if (!exp_err) model.push_back(r_data);
            end else begin
                exp_err = (model.size() == 0);
                if (!exp_err) exp_rd = model.pop_back();
            end
            do_txn(who, r_cmd, r_data, g_err, g_rd, lat, g_ack);
            check($sformatf("rnd%0d_err", i), int'(g_err), int'(exp_err));
            check($sformatf("rnd%0d_rdata", i), int'(g_rd), int'(exp_rd));
            check($sformatf("rnd%0d_lat", i), lat, exp_err ? 1 : 3);
            check($sformatf("rnd%0d_level", i), int'(level), model.size());
        end

        check("other_ack_quiet", stray, 0);
        check("level_flag_consistency", cons_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
